// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter that shares one data-memory port between four cores.
// Each transaction runs IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> DONE.
module dmem_rr_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0]          wren,
  input  logic [4*ADDR_W-1:0] addr_in,
  input  logic [4*DATA_W-1:0] wdata_in,
  output logic [3:0]          gnt,
  output logic [3:0]          done,
  output logic [DATA_W-1:0]   rdata_out,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data,
  output logic                mem_wren,
  input  logic [DATA_W-1:0]   mem_q,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [1:0] WAIT_LAST = (MEM_LAT > 0) ? 2'(MEM_LAT - 1) : 2'd0;

  state_t     state;
  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] wait_cnt;
  logic       any_req;
  logic       owner_wr;

  // Search starts one past the previous winner, so the last served core ranks lowest.
  always_comb begin
    winner  = last;
    any_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!any_req && req[last + 2'(k)]) begin
        winner  = last + 2'(k);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 2'd3;
      wait_cnt    <= 2'd0;
      owner_wr    <= 1'b0;
      gnt         <= 4'd0;
      done        <= 4'd0;
      busy        <= 1'b0;
      mem_wren    <= 1'b0;
      rdata_out   <= '0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      done     <= 4'd0;
      mem_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= ACCESS;
            last        <= winner;
            owner_wr    <= wren[winner];
            mem_wren    <= wren[winner];
            mem_address <= addr_in[winner*ADDR_W +: ADDR_W];
            mem_data    <= wdata_in[winner*DATA_W +: DATA_W];
            gnt         <= 4'b0001 << winner;
            busy        <= 1'b1;
          end
        end
        ACCESS: begin
          if (MEM_LAT > 0) begin
            state    <= WAIT;
            wait_cnt <= WAIT_LAST;
          end else begin
            state <= DONE;
            done  <= gnt;
            if (!owner_wr) rdata_out <= mem_q;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            state <= DONE;
            done  <= gnt;
            if (!owner_wr) rdata_out <= mem_q;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt   <= 4'd0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Bench for dmem_rr_arbiter: one instance with MEM_LAT=0 and one with MEM_LAT=1,
// each checked every cycle against a transaction-level reference model.
module tb_dmem_rr_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_s   [2];
  logic [3:0]  req_s   [2];
  logic [3:0]  wren_s  [2];
  logic [63:0] addr_s  [2];
  logic [31:0] wdata_s [2];

  logic [3:0]  gnt0, gnt1, done0, done1;
  logic [7:0]  rdata0, rdata1, mdata0, mdata1, mq0, mq1;
  logic [15:0] maddr0, maddr1;
  logic        mwren0, mwren1, busy0, busy1;

  logic [7:0]  dmem0 [256];
  logic [7:0]  dmem1 [256];

  // Reference model: m_t is the cycle number within the current transaction, 0 when idle.
  int          m_t    [2];
  int          m_win  [2];
  int          m_last [2];
  bit          m_wr   [2];
  logic [15:0] m_addr [2];
  logic [7:0]  m_data [2];
  logic [7:0]  m_rdata[2];
  logic [7:0]  mm     [2][256];

  int checks   = 0;
  int failures = 0;

  dmem_rr_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(0)) dut0 (
    .clock(clock), .rst(rst_s[0]), .req(req_s[0]), .wren(wren_s[0]),
    .addr_in(addr_s[0]), .wdata_in(wdata_s[0]), .gnt(gnt0), .done(done0),
    .rdata_out(rdata0), .mem_address(maddr0), .mem_data(mdata0),
    .mem_wren(mwren0), .mem_q(mq0), .busy(busy0)
  );

  dmem_rr_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(1)) dut1 (
    .clock(clock), .rst(rst_s[1]), .req(req_s[1]), .wren(wren_s[1]),
    .addr_in(addr_s[1]), .wdata_in(wdata_s[1]), .gnt(gnt1), .done(done1),
    .rdata_out(rdata1), .mem_address(maddr1), .mem_data(mdata1),
    .mem_wren(mwren1), .mem_q(mq1), .busy(busy1)
  );

  assign mq0 = dmem0[maddr0[7:0]];
  assign mq1 = dmem1[maddr1[7:0]];

  always @(posedge clock) if (mwren0 === 1'b1) dmem0[maddr0[7:0]] <= mdata0;
  always @(posedge clock) if (mwren1 === 1'b1) dmem1[maddr1[7:0]] <= mdata1;

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(int n, int i, bit r, bit w, logic [15:0] a, logic [7:0] d);
    req_s[n][i]            = r;
    wren_s[n][i]           = w;
    addr_s[n][i*16 +: 16]  = a;
    wdata_s[n][i*8 +: 8]   = d;
  endtask

  // Predicts the effect of the coming rising edge; latency for instance n is n cycles.
  task automatic modelAdvance(int n);
    int lat = n;
    if (m_t[n] == 1 && m_wr[n]) mm[n][m_addr[n][7:0]] = m_data[n];
    if (rst_s[n]) begin
      m_t[n] = 0; m_last[n] = 3; m_wr[n] = 0;
      m_rdata[n] = 8'h00; m_addr[n] = 16'h0000; m_data[n] = 8'h00;
    end else if (m_t[n] == 0) begin
      for (int k = 1; k <= 4; k++) begin
        int idx = (m_last[n] + k) % 4;
        if (m_t[n] == 0 && req_s[n][idx]) begin
          m_t[n]    = 1;
          m_win[n]  = idx;
          m_last[n] = idx;
          m_wr[n]   = wren_s[n][idx];
          m_addr[n] = addr_s[n][idx*16 +: 16];
          m_data[n] = wdata_s[n][idx*8 +: 8];
        end
      end
    end else begin
      if (m_t[n] == 1 + lat && !m_wr[n]) m_rdata[n] = mm[n][m_addr[n][7:0]];
      m_t[n] = (m_t[n] == 2 + lat) ? 0 : m_t[n] + 1;
    end
  endtask

  task automatic compareAll(int n);
    int lat = n;
    logic [3:0]  g, d, eg, ed;
    logic [7:0]  rd, md;
    logic [15:0] ma;
    logic        mw, bz;
    if (n == 0) begin
      g = gnt0; d = done0; rd = rdata0; md = mdata0; ma = maddr0; mw = mwren0; bz = busy0;
    end else begin
      g = gnt1; d = done1; rd = rdata1; md = mdata1; ma = maddr1; mw = mwren1; bz = busy1;
    end
    eg = (m_t[n] != 0) ? 4'(1 << m_win[n]) : 4'd0;
    ed = (m_t[n] == 2 + lat) ? 4'(1 << m_win[n]) : 4'd0;
    checkOutput($sformatf("L%0d gnt", n), 32'(g), 32'(eg));
    checkOutput($sformatf("L%0d done", n), 32'(d), 32'(ed));
    checkOutput($sformatf("L%0d busy", n), 32'(bz), 32'(m_t[n] != 0));
    checkOutput($sformatf("L%0d mem_wren", n), 32'(mw), 32'(m_t[n] == 1 && m_wr[n]));
    checkOutput($sformatf("L%0d mem_address", n), 32'(ma), 32'(m_addr[n]));
    checkOutput($sformatf("L%0d mem_data", n), 32'(md), 32'(m_data[n]));
    checkOutput($sformatf("L%0d rdata_out", n), 32'(rd), 32'(m_rdata[n]));
  endtask

  task automatic tick();
    for (int n = 0; n < 2; n++) modelAdvance(n);
    @(posedge clock);
    @(negedge clock);
    for (int n = 0; n < 2; n++) compareAll(n);
  endtask

  task automatic newRequest(int n, int i);
    applyStimulus(n, i, 1'b1, 1'($urandom_range(1)),
                  {8'($urandom), 4'h0, 4'($urandom)}, 8'($urandom));
  endtask

  // Requesters honour the handshake except for occasional early deassert after grant.
  task automatic randomStimulus(int n);
    int lat = n;
    rst_s[n] = ($urandom_range(127) == 0);
    for (int i = 0; i < 4; i++) begin
      bit at_done   = (m_t[n] == 2 + lat) && (m_win[n] == i);
      bit in_flight = (m_t[n] != 0) && (m_t[n] < 2 + lat) && (m_win[n] == i);
      if (at_done) begin
        if ($urandom_range(1) == 0) req_s[n][i] = 1'b0;
        else newRequest(n, i);
      end else if (!req_s[n][i]) begin
        if ($urandom_range(2) == 0) newRequest(n, i);
      end else if (in_flight && $urandom_range(7) == 0) begin
        applyStimulus(n, i, 1'b0, 1'($urandom_range(1)), 16'($urandom), 8'($urandom));
      end
    end
  endtask

  initial begin
    logic [7:0] v;
    for (int n = 0; n < 2; n++) begin
      rst_s[n] = 1'b1; req_s[n] = 4'd0; wren_s[n] = 4'd0;
      addr_s[n] = 64'd0; wdata_s[n] = 32'd0;
    end
    for (int a = 0; a < 256; a++) begin
      v = 8'($urandom); dmem0[a] = v; mm[0][a] = v;
      v = 8'($urandom); dmem1[a] = v; mm[1][a] = v;
    end
    @(negedge clock);
    tick();
    checkOutput("reset gnt", 32'(gnt1), 32'h0);
    checkOutput("reset busy", 32'(busy1), 32'h0);
    checkOutput("reset mem_address", 32'(maddr1), 32'h0);
    checkOutput("reset rdata_out", 32'(rdata1), 32'h0);
    req_s[1] = 4'hF;
    tick();
    checkOutput("req ignored in reset", 32'(busy1), 32'h0);
    rst_s[0] = 1'b0; rst_s[1] = 1'b0; req_s[1] = 4'h0;
    tick();

    // Zero-latency instance: write, then a read whose requester drops req right after grant.
    applyStimulus(0, 0, 1'b1, 1'b1, 16'h0020, 8'h5A);
    tick();
    tick();
    checkOutput("lat0 write done", 32'(done0), 32'h1);
    applyStimulus(0, 0, 1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    applyStimulus(0, 1, 1'b1, 1'b0, 16'h0020, 8'h00);
    tick();
    checkOutput("lat0 read gnt", 32'(gnt0), 32'h2);
    applyStimulus(0, 1, 1'b0, 1'b1, 16'hBEEF, 8'h11);
    tick();
    checkOutput("lat0 read done", 32'(done0), 32'h2);
    checkOutput("lat0 read rdata", 32'(rdata0), 32'h5A);
    tick();
    checkOutput("lat0 idle done", 32'(done0), 32'h0);

    // Core 0 writes 0xA5 to 0x0010, then core 2 reads it back.
    applyStimulus(1, 0, 1'b1, 1'b1, 16'h0010, 8'hA5);
    tick();
    checkOutput("wr mem_wren", 32'(mwren1), 32'h1);
    checkOutput("wr mem_address", 32'(maddr1), 32'h0010);
    checkOutput("wr mem_data", 32'(mdata1), 32'hA5);
    tick();
    checkOutput("wr mem_wren wait", 32'(mwren1), 32'h0);
    tick();
    checkOutput("wr done", 32'(done1), 32'h1);
    applyStimulus(1, 0, 1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    applyStimulus(1, 2, 1'b1, 1'b0, 16'h0010, 8'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rd gnt", 32'(gnt1), 32'h4);
    end
    checkOutput("rd done", 32'(done1), 32'h4);
    checkOutput("rd rdata", 32'(rdata1), 32'hA5);
    applyStimulus(1, 2, 1'b0, 1'b0, 16'h0000, 8'h00);
    tick();

    // All four cores requesting after reset: order 0,1,2,3,0.
    rst_s[1] = 1'b1;
    tick();
    rst_s[1] = 1'b0; req_s[1] = 4'hF; wren_s[1] = 4'h0;
    for (int g = 0; g < 5; g++) begin
      tick();
      checkOutput("rr4 gnt", 32'(gnt1), 32'(1 << (g % 4)));
      tick();
      checkOutput("rr4 no early done", 32'(done1), 32'h0);
      tick();
      checkOutput("rr4 done", 32'(done1), 32'(1 << (g % 4)));
      if (g == 4) req_s[1] = 4'h0;
      tick();
      checkOutput("rr4 single pulse", 32'(done1), 32'h0);
    end

    // Two cores requesting after reset alternate 0,1,0,1.
    rst_s[1] = 1'b1;
    tick();
    rst_s[1] = 1'b0; req_s[1] = 4'h3;
    for (int g = 0; g < 4; g++) begin
      tick();
      checkOutput("rr2 gnt", 32'(gnt1), 32'(1 << (g % 2)));
      tick();
      tick();
      if (g == 3) req_s[1] = 4'h0;
      tick();
    end

    // Reset in the WAIT cycle of a write abandons it; core 1 is then served.
    applyStimulus(1, 3, 1'b1, 1'b1, 16'h0044, 8'h3C);
    tick();
    tick();
    rst_s[1] = 1'b1;
    tick();
    checkOutput("abort gnt", 32'(gnt1), 32'h0);
    checkOutput("abort busy", 32'(busy1), 32'h0);
    checkOutput("abort mem_wren", 32'(mwren1), 32'h0);
    checkOutput("abort done", 32'(done1), 32'h0);
    rst_s[1] = 1'b0; req_s[1] = 4'h2;
    tick();
    checkOutput("after abort gnt", 32'(gnt1), 32'h2);
    tick();
    tick();
    checkOutput("after abort done", 32'(done1), 32'h2);
    req_s[1] = 4'h0;
    tick();

    for (int c = 0; c < 3000; c++) begin
      randomStimulus(0);
      randomStimulus(1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
